// File: rtl/v_hier_pkg.sv
// Shared defaults and helpers for the v_hier channel-vector blocks.
package v_hier_pkg;

  localparam int DEFAULT_NCH   = 2;
  localparam int DEFAULT_DEPTH = 2;
  localparam int DEFAULT_CNTW  = 8;

  // Increment value and stop at the largest number representable in width
  // bits. Callers keep width at 32 or below.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return (value >= max_val) ? max_val : value + 32'd1;
  endfunction

endpackage

// File: rtl/v_hier_stage.sv
// One elastic pipeline register: NCH data bits plus a valid flag.
// The stage can take a new word when it is empty or when the stage
// below is taking its current word.
module v_hier_stage
  import v_hier_pkg::*;
#(
  parameter int NCH = DEFAULT_NCH
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           up_valid,
  input  logic [NCH-1:0] up_data,
  input  logic           dn_ready,
  output logic           valid,
  output logic [NCH-1:0] data,
  output logic           rdy
);

  assign rdy = !valid | dn_ready;

  // Load from upstream when this stage is free to move; otherwise hold.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking (<=) so every stage samples
    // its neighbour's pre-edge value and the chain shifts by exactly one.
    if (reset) begin
      valid <= 1'b0;
      // NOTE: data is cleared too, so qvec reads 0 straight after reset
      // rather than leftover contents from before the reset.
      data  <= '0;
    end else if (rdy) begin
      valid <= up_valid;
      // Bubbles leave data untouched, so qvec keeps the last real word.
      if (up_valid) begin
        data <= up_data;
      end
    end
  end

endmodule

// File: rtl/v_hier_vecsub.sv
// N-channel elastic pipeline with per-channel inversion and a saturating
// count of output transfers. in_ready is combinational from out_ready
// through the stage ready chain, which lets a full pipeline accept and
// emit in the same cycle.
module v_hier_vecsub
  import v_hier_pkg::*;
#(
  parameter int NCH   = DEFAULT_NCH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int CNTW  = DEFAULT_CNTW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NCH-1:0]  avec,
  input  logic [NCH-1:0]  inv_mask,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [NCH-1:0]  qvec,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CNTW-1:0] xfer_cnt
);

  if (DEPTH < 1) begin : g_bad_depth
    $error("v_hier_vecsub: DEPTH must be at least 1");
  end
  if (NCH < 1) begin : g_bad_nch
    $error("v_hier_vecsub: NCH must be at least 1");
  end
  if (CNTW < 1 || CNTW > 32) begin : g_bad_cntw
    $error("v_hier_vecsub: CNTW must be between 1 and 32");
  end

  logic [DEPTH-1:0] stage_valid;
  logic [DEPTH-1:0] stage_rdy;
  logic [DEPTH-1:0] up_valid;
  logic [DEPTH-1:0] dn_ready;
  logic [NCH-1:0]   stage_data [DEPTH];
  logic [NCH-1:0]   up_data    [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    // Stage 0 takes the inverted input word; later stages take the one above.
    if (i == 0) begin : g_head
      assign up_valid[i] = in_valid;
      assign up_data[i]  = avec ^ inv_mask;
    end else begin : g_body
      assign up_valid[i] = stage_valid[i-1];
      assign up_data[i]  = stage_data[i-1];
    end

    // The last stage is released by the consumer, the rest by the next stage.
    if (i == DEPTH - 1) begin : g_tail
      assign dn_ready[i] = out_ready;
    end else begin : g_link
      assign dn_ready[i] = stage_rdy[i+1];
    end

    v_hier_stage #(
      .NCH (NCH)
    ) u_stage (
      .clk      (clk),
      .reset    (reset),
      .up_valid (up_valid[i]),
      .up_data  (up_data[i]),
      .dn_ready (dn_ready[i]),
      .valid    (stage_valid[i]),
      .data     (stage_data[i]),
      .rdy      (stage_rdy[i])
    );
  end

  assign in_ready  = stage_rdy[0] & !reset;
  assign out_valid = stage_valid[DEPTH-1];
  assign qvec      = stage_data[DEPTH-1];

  // Count each word the consumer takes, holding at the all-ones value.
  always_ff @(posedge clk) begin
    if (reset) begin
      xfer_cnt <= '0;
    end else if (out_valid && out_ready) begin
      xfer_cnt <= CNTW'(sat_inc(32'(xfer_cnt), CNTW));
    end
  end

endmodule

// File: tb/tb_v_hier_vecsub.sv
// Bench for v_hier_vecsub. Three instances cover the parameter sets the
// scenarios need: A (NCH=2, DEPTH=3), B (NCH=4, DEPTH=2), C (CNTW=3).
// Inputs change on the falling edge; outputs are checked 1 time unit later.
module tb_v_hier_vecsub;

  localparam int B_DEPTH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance A: NCH=2, DEPTH=3, CNTW=8
  logic       a_reset, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [1:0] a_avec, a_inv, a_qvec;
  logic [7:0] a_cnt;
  // Instance B: NCH=4, DEPTH=2, CNTW=8
  logic       b_reset, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [3:0] b_avec, b_inv, b_qvec;
  logic [7:0] b_cnt;
  // Instance C: NCH=2, DEPTH=2, CNTW=3
  logic       c_reset, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [1:0] c_avec, c_inv, c_qvec;
  logic [2:0] c_cnt;

  v_hier_vecsub #(.NCH(2), .DEPTH(3), .CNTW(8)) u_a (
    .clk(clk), .reset(a_reset), .avec(a_avec), .inv_mask(a_inv),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .qvec(a_qvec),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .xfer_cnt(a_cnt)
  );
  v_hier_vecsub #(.NCH(4), .DEPTH(B_DEPTH), .CNTW(8)) u_b (
    .clk(clk), .reset(b_reset), .avec(b_avec), .inv_mask(b_inv),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .qvec(b_qvec),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .xfer_cnt(b_cnt)
  );
  v_hier_vecsub #(.NCH(2), .DEPTH(2), .CNTW(3)) u_c (
    .clk(clk), .reset(c_reset), .avec(c_avec), .inv_mask(c_inv),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .qvec(c_qvec),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .xfer_cnt(c_cnt)
  );

  // Reference model for instance B: words in flight with their stage index.
  logic [3:0] mq_data[$];
  int         mq_pos[$];

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      #1;
      total++;
      if (a_in_ready !== 1'b0 || a_out_valid !== 1'b0 || a_qvec !== 2'b00 || a_cnt !== 8'd0) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d got rdy=%b ov=%b q=%b cnt=%0d exp rdy=0 ov=0 q=00 cnt=0",
                 i, a_in_ready, a_out_valid, a_qvec, a_cnt);
      end
      #1;
    end
    @(negedge clk);
    a_reset = 1'b0; b_reset = 1'b0; c_reset = 1'b0;
    #1;
    total++;
    if (a_in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_ready got=%b exp=1", a_in_ready);
    end
    a_in_valid = 1'b0;
    total++;
    if (b_cnt !== 8'd0 || c_cnt !== 3'd0) begin
      bad++;
      $display("FAIL reset_other_cnt got b=%0d c=%0d exp 0 0", b_cnt, c_cnt);
    end
  endtask

  task automatic test_latency();
    @(negedge clk);
    a_out_ready = 1'b1; a_in_valid = 1'b1; a_avec = 2'b01; a_inv = 2'b10;
    next_cycle();
    a_in_valid = 1'b0; a_inv = 2'b00;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (a_out_valid !== (i == 2)) begin
        bad++;
        $display("FAIL latency_valid after_edge=%0d got=%b exp=%b", i + 1, a_out_valid, (i == 2));
      end
      if (i == 2) begin
        total++;
        if (a_qvec !== 2'b11) begin
          bad++;
          $display("FAIL latency_data got=%b exp=11", a_qvec);
        end
      end
      next_cycle();
    end
    #1;
    total++;
    if (a_cnt !== 8'd1) begin
      bad++;
      $display("FAIL latency_cnt got=%0d exp=1", a_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] exp_q [3];
    exp_q[0] = 4'd1; exp_q[1] = 4'd2; exp_q[2] = 4'd3;
    @(negedge clk);
    b_inv = 4'h0; b_out_ready = 1'b0; b_in_valid = 1'b1;
    for (int w = 1; w <= 2; w++) begin
      b_avec = 4'(w);
      #1;
      total++;
      if (b_in_ready !== 1'b1) begin
        bad++;
        $display("FAIL bp_accept word=%0d got rdy=%b exp=1", w, b_in_ready);
      end
      next_cycle();
    end
    b_avec = 4'd3;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++;
      if (b_in_ready !== 1'b0 || b_out_valid !== 1'b1 || b_qvec !== 4'd1) begin
        bad++;
        $display("FAIL bp_full cyc=%0d got rdy=%b ov=%b q=%0d exp rdy=0 ov=1 q=1",
                 i, b_in_ready, b_out_valid, b_qvec);
      end
      if (i == 0) next_cycle();
    end
    b_out_ready = 1'b1;
    #1;
    total++;
    if (b_in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_pushpop got rdy=%b exp=1", b_in_ready);
    end
    next_cycle();
    b_in_valid = 1'b0;
    for (int i = 1; i < 3; i++) begin
      #1;
      total++;
      if (b_out_valid !== 1'b1 || b_qvec !== exp_q[i]) begin
        bad++;
        $display("FAIL bp_drain idx=%0d got ov=%b q=%0d exp ov=1 q=%0d", i, b_out_valid, b_qvec, exp_q[i]);
      end
      next_cycle();
    end
    #1;
    total++;
    if (b_out_valid !== 1'b0 || b_qvec !== 4'd3 || b_cnt !== 8'd3) begin
      bad++;
      $display("FAIL bp_end got ov=%b q=%0d cnt=%0d exp ov=0 q=3 cnt=3", b_out_valid, b_qvec, b_cnt);
    end
  endtask

  task automatic test_throughput();
    @(negedge clk);
    b_reset = 1'b1; b_in_valid = 1'b0;
    next_cycle();
    b_reset = 1'b0; b_out_ready = 1'b1; b_inv = 4'h0;
    for (int i = 0; i <= 18; i++) begin
      b_in_valid = (i < 16);
      b_avec     = 4'(i);
      #1;
      if (i < 16) begin
        total++;
        if (b_in_ready !== 1'b1) begin
          bad++;
          $display("FAIL tp_ready cyc=%0d got=%b exp=1", i, b_in_ready);
        end
      end
      total++;
      if (b_out_valid !== (i >= 2 && i < 18)) begin
        bad++;
        $display("FAIL tp_valid cyc=%0d got=%b exp=%b", i, b_out_valid, (i >= 2 && i < 18));
      end else if (i >= 2 && i < 18 && b_qvec !== 4'(i - 2)) begin
        bad++;
        $display("FAIL tp_data cyc=%0d got=%0d exp=%0d", i, b_qvec, i - 2);
      end
      next_cycle();
    end
    b_in_valid = 1'b0;
    #1;
    total++;
    if (b_cnt !== 8'd16) begin
      bad++;
      $display("FAIL tp_cnt got=%0d exp=16", b_cnt);
    end
  endtask

  task automatic test_saturation();
    int done;
    @(negedge clk);
    c_inv = 2'b00; c_out_ready = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      c_in_valid = (i < 10);
      c_avec     = 2'(i);
      #1;
      done = (i - 2 < 0) ? 0 : ((i - 2 > 10) ? 10 : i - 2);
      total++;
      if (c_cnt !== 3'((done > 7) ? 7 : done)) begin
        bad++;
        $display("FAIL sat_cnt cyc=%0d got=%0d exp=%0d", i, c_cnt, (done > 7) ? 7 : done);
      end
      next_cycle();
    end
    c_in_valid = 1'b0;
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    a_out_ready = 1'b1; a_inv = 2'b00; a_in_valid = 1'b1; a_avec = 2'b01;
    next_cycle();
    a_avec = 2'b10;
    next_cycle();
    a_in_valid = 1'b0; a_reset = 1'b1;
    #1;
    total++;
    if (a_in_ready !== 1'b0) begin
      bad++;
      $display("FAIL mid_ready_in_reset got=%b exp=0", a_in_ready);
    end
    next_cycle();
    a_reset = 1'b0;
    #1;
    total++;
    if (a_qvec !== 2'b00 || a_cnt !== 8'd0) begin
      bad++;
      $display("FAIL mid_cleared got q=%b cnt=%0d exp q=00 cnt=0", a_qvec, a_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (a_out_valid !== 1'b0) begin
        bad++;
        $display("FAIL mid_ghost cyc=%0d got ov=%b q=%b exp ov=0", i, a_out_valid, a_qvec);
      end
      next_cycle();
      #1;
    end
    a_in_valid = 1'b1; a_avec = 2'b10;
    next_cycle();
    a_in_valid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      #1;
      total++;
      if (a_out_valid !== (j == 2) || (j == 2 && a_qvec !== 2'b10)) begin
        bad++;
        $display("FAIL mid_next after_edge=%0d got ov=%b q=%b exp ov=%b q=10", j + 1, a_out_valid, a_qvec, (j == 2));
      end
      next_cycle();
    end
    #1;
    total++;
    if (a_cnt !== 8'd1) begin
      bad++;
      $display("FAIL mid_cnt got=%0d exp=1", a_cnt);
    end
  endtask

  task automatic test_random();
    int         exp_cnt;
    logic       exp_rdy, exp_ov, consumed, accepted;
    logic [3:0] word;
    int         prev_pos;
    @(negedge clk);
    b_reset = 1'b1; b_in_valid = 1'b0;
    next_cycle();
    b_reset = 1'b0;
    mq_data.delete();
    mq_pos.delete();
    exp_cnt = 0;
    for (int c = 0; c < 400; c++) begin
      b_in_valid  = 1'($urandom_range(0, 1));
      b_avec      = 4'($urandom);
      b_inv       = 4'($urandom);
      b_out_ready = ($urandom_range(0, 9) < 7);
      #1;
      // Capacity DEPTH words; a full pipe still accepts when the consumer takes.
      exp_rdy = (mq_data.size() < B_DEPTH) || b_out_ready;
      exp_ov  = (mq_data.size() > 0) && (mq_pos[0] == B_DEPTH - 1);
      total++;
      if (b_in_ready !== exp_rdy) begin
        bad++;
        $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", c, b_in_ready, exp_rdy);
      end
      total++;
      if (b_out_valid !== exp_ov) begin
        bad++;
        $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", c, b_out_valid, exp_ov);
      end else if (exp_ov && b_qvec !== mq_data[0]) begin
        bad++;
        $display("FAIL rnd_data cyc=%0d got=%h exp=%h", c, b_qvec, mq_data[0]);
      end
      total++;
      if (b_cnt !== 8'(exp_cnt)) begin
        bad++;
        $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", c, b_cnt, exp_cnt);
      end
      consumed = exp_ov && b_out_ready;
      accepted = b_in_valid && exp_rdy;
      word     = b_avec ^ b_inv;
      next_cycle();
      if (consumed) begin
        void'(mq_data.pop_front());
        void'(mq_pos.pop_front());
        if (exp_cnt < 255) exp_cnt++;
      end
      // Each word moves one stage closer unless the word ahead blocks it.
      prev_pos = B_DEPTH;
      for (int k = 0; k < mq_pos.size(); k++) begin
        mq_pos[k] = (mq_pos[k] + 1 < prev_pos - 1) ? mq_pos[k] + 1 : prev_pos - 1;
        prev_pos  = mq_pos[k];
      end
      if (accepted) begin
        mq_data.push_back(word);
        mq_pos.push_back(0);
      end
    end
    b_in_valid = 1'b0;
  endtask

  initial begin
    a_reset = 1'b1; b_reset = 1'b1; c_reset = 1'b1;
    a_in_valid = 1'b1; a_avec = 2'b11; a_inv = 2'b00; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_avec = 4'h0;  b_inv = 4'h0;  b_out_ready = 1'b0;
    c_in_valid = 1'b0; c_avec = 2'b00; c_inv = 2'b00; c_out_ready = 1'b0;
    test_reset();
    test_latency();
    test_backpressure();
    test_throughput();
    test_saturation();
    test_reset_midflight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
